// File: rtl/branch_flush_ctrl_pkg.sv
// Shared definitions for the branch redirect / flush controller.
// Contents: RV32 opcode constants, branch funct3 constants, the 2-bit
// controller state encoding and the redirect-target helper.
package branch_flush_ctrl_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    // Redirect address: wraps modulo 2^32, bit 0 is never set on a fetch PC.
    function automatic logic [31:0] calc_target(input logic [31:0] pc, input logic [31:0] imm);
        return (pc + imm) & 32'hFFFF_FFFE;
    endfunction

endpackage

// File: rtl/branch_flush_ctrl_br_cond_eval.sv
// Combinational branch condition evaluator.
// Maps funct3 and the rs1-rs2 subtraction flags to a taken decision.
// Ports: funct3, flag_v/c/n/z in; taken (condition true), illegal
// (funct3 010/011, never taken) out. Carry convention: C=1 means no borrow.
module br_cond_eval
    import branch_flush_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       flag_v,
    input  logic       flag_c,
    input  logic       flag_n,
    input  logic       flag_z,
    output logic       taken,
    output logic       illegal
);

    // Decode the condition selected by funct3.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = flag_z;
            F3_BNE:  taken = ~flag_z;
            F3_BLT:  taken = flag_n ^ flag_v;
            F3_BGE:  taken = ~(flag_n ^ flag_v);
            F3_BLTU: taken = ~flag_c;
            F3_BGEU: taken = flag_c;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Branch redirect and pipeline flush controller for the 5-stage pipeline.
// Detects taken EX-stage branches, issues a one-cycle registered PC redirect
// and holds the IF/ID and ID/EX flush lines for FLUSH_CYCLES cycles in total.
// Ports: clk, rst_n (async active-low), ex_valid, stall_in, opcode, funct3,
// flag_v/c/n/z, ex_pc, ex_imm in; pc_sel, pc_target, flush_if_id,
// flush_id_ex, busy, illegal_br, taken_cnt out (all registered).
// Build option: define BRANCH_JAL_EN to also redirect on JAL.
module branch_flush_ctrl
    import branch_flush_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             stall_in,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             flag_v,
    input  logic             flag_c,
    input  logic             flag_n,
    input  logic             flag_z,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             busy,
    output logic             illegal_br,
    output logic [CNT_W-1:0] taken_cnt
);

    // FLUSH follows the one REDIRECT cycle, so it needs FLUSH_CYCLES-1 cycles.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             cond_taken_s;
    logic             cond_illegal_s;
    logic             is_branch_s;
    logic             is_jal_s;
    logic             redirect_req_s;
    logic             illegal_req_s;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [2:0]       cnt_r;
    logic [2:0]       cnt_nxt_s;
    logic             pc_sel_r;
    logic [31:0]      pc_target_r;
    logic             flush_r;
    logic             busy_r;
    logic             illegal_br_r;
    logic [CNT_W-1:0] taken_cnt_r;

    br_cond_eval u_cond (
        .funct3  (funct3),
        .flag_v  (flag_v),
        .flag_c  (flag_c),
        .flag_n  (flag_n),
        .flag_z  (flag_z),
        .taken   (cond_taken_s),
        .illegal (cond_illegal_s)
    );

    assign is_branch_s = ex_valid && (opcode == OPC_BRANCH);
`ifdef BRANCH_JAL_EN
    assign is_jal_s = ex_valid && (opcode == OPC_JAL);
`else
    assign is_jal_s = 1'b0;
`endif
    assign redirect_req_s = (is_branch_s && cond_taken_s) || is_jal_s;
    assign illegal_req_s  = is_branch_s && cond_illegal_s;

    // Next-state logic; EX inputs only matter in IDLE (others are wrong-path).
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (stall_in) begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect_req_s) begin
                        state_nxt_s = ST_REDIRECT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    if (FLUSH_CYCLES == 1) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r == 3'd0) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 3'd0;
                end
            endcase
        end
    end

    // State and output registers; a stall freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 3'd0;
            pc_sel_r     <= 1'b0;
            pc_target_r  <= 32'd0;
            flush_r      <= 1'b0;
            busy_r       <= 1'b0;
            illegal_br_r <= 1'b0;
            taken_cnt_r  <= {CNT_W{1'b0}};
        end else if (!stall_in) begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            pc_sel_r     <= (state_nxt_s == ST_REDIRECT);
            flush_r      <= (state_nxt_s != ST_IDLE);
            busy_r       <= (state_nxt_s != ST_IDLE);
            illegal_br_r <= (state_r == ST_IDLE) && illegal_req_s;
            if ((state_r == ST_IDLE) && redirect_req_s) begin
                pc_target_r <= calc_target(ex_pc, ex_imm);
                if (taken_cnt_r != CNT_MAX) begin
                    taken_cnt_r <= taken_cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign pc_sel      = pc_sel_r;
    assign pc_target   = pc_target_r;
    assign flush_if_id = flush_r;
    assign flush_id_ex = flush_r;
    assign busy        = busy_r;
    assign illegal_br  = illegal_br_r;
    assign taken_cnt   = taken_cnt_r;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Self-checking bench for branch_flush_ctrl (FLUSH_CYCLES=2, CNT_W=4).
// Flags are derived from real rs1/rs2 operands; the reference model decides
// taken branches by comparing the operands directly and tracks the flush
// window as a count of busy cycles remaining.
module tb_branch_flush_ctrl;

    localparam int FC      = 2;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid;
    logic          stall_in;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          flag_v, flag_c, flag_n, flag_z;
    logic [31:0]   ex_pc, ex_imm;
    logic          pc_sel;
    logic [31:0]   pc_target;
    logic          flush_if_id, flush_id_ex, busy, illegal_br;
    logic [CW-1:0] taken_cnt;

    logic [31:0]   op_a, op_b;

    // reference model state
    int            m_busy_left;
    logic          m_pc_sel;
    logic [31:0]   m_target;
    logic          m_illegal;
    int            m_cnt;

    int            checks = 0;
    int            errors = 0;
    int            cnt_before;

    branch_flush_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .stall_in    (stall_in),
        .opcode      (opcode),
        .funct3      (funct3),
        .flag_v      (flag_v),
        .flag_c      (flag_c),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .ex_pc       (ex_pc),
        .ex_imm      (ex_imm),
        .pc_sel      (pc_sel),
        .pc_target   (pc_target),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .busy        (busy),
        .illegal_br  (illegal_br),
        .taken_cnt   (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present rs1/rs2 to a virtual ALU and drive the resulting subtraction flags.
    task automatic drive_ops(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        op_a   = a;
        op_b   = b;
        d      = a - b;
        flag_z = (d == 32'd0);
        flag_n = d[31];
        flag_c = (a >= b);
        flag_v = (a[31] != b[31]) && (d[31] != a[31]);
    endtask

    task automatic present(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm);
        ex_valid = 1'b1;
        opcode   = opc;
        funct3   = f3;
        ex_pc    = pc;
        ex_imm   = imm;
        drive_ops(a, b);
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        opcode   = 7'h13;
        funct3   = 3'd0;
        ex_pc    = 32'd0;
        ex_imm   = 32'd0;
        drive_ops(32'd1, 32'd2);
    endtask

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy_left = 0;
        m_pc_sel    = 1'b0;
        m_target    = 32'd0;
        m_illegal   = 1'b0;
        m_cnt       = 0;
    endtask

    // One clock of reference behaviour, using the inputs sampled at the edge.
    task automatic model_step();
        logic is_br, tk;
        if (stall_in) return;
        if (m_busy_left > 0) begin
            m_busy_left--;
            m_pc_sel  = 1'b0;
            m_illegal = 1'b0;
        end else begin
            is_br = ex_valid && (opcode == 7'b1100011);
            tk    = is_br && ref_taken(funct3, op_a, op_b);
`ifdef BRANCH_JAL_EN
            if (ex_valid && (opcode == 7'b1101111)) tk = 1'b1;
`endif
            if (tk) begin
                m_busy_left = FC;
                m_pc_sel    = 1'b1;
                m_target    = (ex_pc + ex_imm) & 32'hFFFF_FFFE;
                m_illegal   = 1'b0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_pc_sel  = 1'b0;
                m_illegal = is_br && (funct3 == 3'd2 || funct3 == 3'd3);
            end
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".pc_sel"},    {31'd0, pc_sel},      {31'd0, m_pc_sel});
        check({ph, ".pc_target"}, pc_target,            m_target);
        check({ph, ".flush_ifid"},{31'd0, flush_if_id}, {31'd0, (m_busy_left > 0)});
        check({ph, ".flush_idex"},{31'd0, flush_id_ex}, {31'd0, (m_busy_left > 0)});
        check({ph, ".busy"},      {31'd0, busy},        {31'd0, (m_busy_left > 0)});
        check({ph, ".illegal"},   {31'd0, illegal_br},  {31'd0, m_illegal});
        check({ph, ".taken_cnt"}, {28'd0, taken_cnt},   m_cnt);
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_step();
        #1;
        check_all(ph);
    endtask

    initial begin
        rst_n    = 1'b1;
        stall_in = 1'b0;
        idle_inputs();
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // BEQ taken: redirect next cycle, flush 2 cycles total
        present(7'b1100011, 3'd0, 32'd7, 32'd7, 32'h100, 32'h20);
        tick("beq");
        check("beq.target_const", pc_target, 32'h120);
        check("beq.cnt_const", {28'd0, taken_cnt}, 32'd1);
        idle_inputs();
        tick("beq.f1");
        check("beq.flush2_const", {31'd0, flush_if_id}, 32'd1);
        tick("beq.f2");
        check("beq.idle_const", {31'd0, busy}, 32'd0);

        // BLTU with C=1 (rs1>=rs2): no activity
        present(7'b1100011, 3'd6, 32'd50, 32'd10, 32'h200, 32'h40);
        tick("bltu_nt");
        // BGEU taken with wrapping target
        present(7'b1100011, 3'd7, 32'd50, 32'd10, 32'hFFFF_FFF0, 32'h20);
        tick("bgeu_wrap");
        check("wrap.target_const", pc_target, 32'h0000_0010);
        idle_inputs();
        tick("wrap.f1");
        tick("wrap.f2");

        // Wrong-path suppression
        cnt_before = int'(taken_cnt);
        present(7'b1100011, 3'd1, 32'd1, 32'd2, 32'h300, 32'h8);
        tick("bne");
        present(7'b1100011, 3'd0, 32'd4, 32'd4, 32'h304, 32'h40);
        tick("wrongpath1");
        present(7'b1100011, 3'd2, 32'd4, 32'd4, 32'h308, 32'h40);
        tick("wrongpath2");
        idle_inputs();
        tick("wrongpath3");
        check("wrongpath.cnt_delta", {28'd0, taken_cnt}, cnt_before + 1);

        // Stall while a taken BLT waits, then stall during FLUSH
        stall_in = 1'b1;
        present(7'b1100011, 3'd4, 32'hFFFF_FFFF, 32'd3, 32'h400, 32'h10);
        for (int i = 0; i < 3; i++) tick("stall_wait");
        check("stall.no_redirect", {31'd0, pc_sel}, 32'd0);
        stall_in = 1'b0;
        tick("stall_release");
        check("stall.redirect", {31'd0, pc_sel}, 32'd1);
        idle_inputs();
        tick("stall.flush");
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) tick("stall_in_flush");
        check("stall.flush_held", {31'd0, flush_id_ex}, 32'd1);
        stall_in = 1'b0;
        tick("stall_done");
        check("stall.idle", {31'd0, busy}, 32'd0);

        // Illegal funct3: one-cycle pulse, no flush
        present(7'b1100011, 3'd2, 32'd5, 32'd5, 32'h500, 32'h10);
        tick("illegal");
        check("illegal.pulse", {31'd0, illegal_br}, 32'd1);
        idle_inputs();
        tick("illegal.after");
        check("illegal.cleared", {31'd0, illegal_br}, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            int sel;
            stall_in = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 5);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            present((sel < 4) ? 7'b1100011 : ((sel == 4) ? 7'b1101111 : 7'b0110011),
                    3'($urandom_range(0, 7)), a, b, $urandom, $urandom);
            ex_valid = ($urandom_range(0, 3) != 0);
            tick("random");
        end
        stall_in = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) tick("drain");

        // Saturation of the taken counter
        for (int i = 0; i < 20; i++) begin
            present(7'b1100011, 3'd0, 32'd9, 32'd9, 32'h600, 32'h4);
            tick("sat.redirect");
            idle_inputs();
            tick("sat.f1");
            tick("sat.f2");
        end
        check("sat.cnt_const", {28'd0, taken_cnt}, 32'hF);

        // Asynchronous reset in the middle of a flush
        present(7'b1100011, 3'd0, 32'd1, 32'd1, 32'h700, 32'h8);
        tick("rst.redirect");
        idle_inputs();
        tick("rst.flush");
        rst_n = 1'b0;
        model_reset();
        #1 check_all("rst.async");
        check("rst.cnt_const", {28'd0, taken_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick("rst.after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
